motor_cmd_spi_rx: RTL and testbench
===================================

Name: motor_cmd_spi_rx

Overview:
SPI-slave command receiver that feeds the motor PWM/direction stage. Accepts 16-bit frames from the MCU and presents registered per-motor sign and 7-bit period commands. Provides a readback of the applied command on SDO. Includes a loss-of-command watchdog that forces both motors to stop.

Parameters:
SYNC_STAGES, 2, flops per synchronizer on sclk/cs_n/sdi (min 2)
WDOG_WIDTH, 24, watchdog counter width
WDOG_LIMIT, 12000000, clk cycles without a valid frame before forced stop (0.25 s at 48 MHz)

Ports:
clk  in  1  system clock; every flop on posedge
reset  in  1  asynchronous, active-low reset (0 = in reset)
sclk  in  1  SPI clock from MCU, async to clk, mode 0
cs_n  in  1  SPI chip select, active low, async
sdi  in  1  SPI MOSI, async
sdo  out  1  SPI MISO, readback data
motor1_sign  out  1  motor 1 direction
motor1_period  out  7  motor 1 period command
motor2_sign  out  1  motor 2 direction
motor2_period  out  7  motor 2 period command
cmd_valid  out  1  one-cycle pulse when a new command is applied
frame_error  out  1  one-cycle pulse when a frame is discarded
wdog_timeout  out  1  high while the watchdog stop is in force

Behaviour:
- Reset (reset=0, async): all outputs 0; bit count 0; watchdog count 0; FSM to WAIT_IDLE.
- Inputs pass through SYNC_STAGES-flop synchronizers, then a 1-flop edge detector. Rising-sclk, cs_n-fall and cs_n-rise events are single-cycle strobes.
- Constraint: clk >= 8x sclk. No behaviour is guaranteed outside this.
- Frame: exactly 16 bits, MSB first. Bits [15:8] = {motor1_sign, motor1_period[6:0]}. Bits [7:0] = {motor2_sign, motor2_period[6:0]}.
- FSM states:
  - WAIT_IDLE: waits for synced cs_n=1, then goes to IDLE. This covers reset release mid-frame, which is ignored.
  - IDLE: on cs_n fall, clear bit count, load the readback register and go to SHIFT. sclk edges are ignored.
  - SHIFT: on each sclk rise, shift sdi into rx_shift and increment bit count. The count saturates at 17. On cs_n rise, go to COMMIT.
  - COMMIT (1 cycle):
    - Bit count 16: update all four motor outputs from rx_shift and pulse cmd_valid in the same cycle. Clear the watchdog and clear wdog_timeout.
    - Bit count 0: ignored, no pulse.
    - Any other count (1-15 or 17): outputs unchanged, frame_error pulses 1 cycle.
    - Always returns to IDLE.
- SDO / readback:
  - The readback register is loaded at cs_n fall with the currently applied 16-bit command, in the same layout.
  - sdo = readback MSB while in SHIFT. The register shifts left on each synced sclk fall.
  - After 16 bits, sdo = 0.
  - sdo = 0 when not in SHIFT.
- Watchdog:
  - Counts every clk while wdog_timeout=0.
  - When the count reaches WDOG_LIMIT-1, the next cycle sets wdog_timeout=1 and forces motor1/2 sign=0 and period=0. The counter then holds.
  - wdog_timeout stays set until the next valid commit.
  - A valid commit in the same cycle as expiry wins: the new command is applied, wdog_timeout=0 and the count is 0.
- Latency: cmd_valid rises SYNC_STAGES+2 clk after the raw cs_n rising edge (±1 for async sampling).
- Outputs are registered. They change only on a valid commit, a watchdog expiry or reset.

Test Plan:
- Valid frame 0xA5_3C (cs low, 16 sclk, cs high) -> one cmd_valid pulse; motor1_sign=1, motor1_period=0x25, motor2_sign=0, motor2_period=0x3C; frame_error stays 0.
- Readback: send 0xA5_3C then frame 0x0000 -> sdo bitstream in the second frame = 0xA53C MSB first; motor outputs go to 0 after the second commit.
- 15-bit frame and 18-bit frame after 0x1234 applied -> each gives one frame_error pulse; outputs stay 0x12/0x34 fields; no cmd_valid.
- cs_n low then high with no sclk -> no cmd_valid, no frame_error. sclk toggling with cs_n high -> no state change.
- WDOG_LIMIT=100, apply 0x7F7F, then idle -> wdog_timeout=1 and all motor outputs 0 at cycle 100 after commit. A new frame 0x0101 clears wdog_timeout and applies 0x01/0x01.
- Assert reset mid-frame (bit 8), release with cs_n still low, finish clocking, raise cs_n -> no cmd_valid and outputs 0. The next full frame is accepted normally.

Source files
------------

// File: rtl/motor_cmd_spi_rx.sv
// SPI-slave (mode 0) receiver for 16-bit motor commands, with SDO readback of the
// applied command and a loss-of-command watchdog that stops both motors.
module motor_cmd_spi_rx #(
   parameter int SYNC_STAGES = 2,
   parameter int WDOG_WIDTH  = 24,
   parameter int WDOG_LIMIT  = 12000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sclk,
   input  logic       cs_n,
   input  logic       sdi,
   output logic       sdo,
   output logic       motor1_sign,
   output logic [6:0] motor1_period,
   output logic       motor2_sign,
   output logic [6:0] motor2_period,
   output logic       cmd_valid,
   output logic       frame_error,
   output logic       wdog_timeout
);

   typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT, COMMIT} state_t;

   localparam logic [WDOG_WIDTH-1:0] WDOG_LAST = WDOG_WIDTH'(WDOG_LIMIT - 1);

   logic [2:0]                   async_in;
   logic [2:0][SYNC_STAGES-1:0] sync_reg;
   logic                         sclk_s, cs_s, sdi_s;
   logic                         sclk_prev_reg, cs_prev_reg;
   logic                         sclk_rise, sclk_fall, cs_fall, cs_rise;

   state_t                       state_reg;
   logic [4:0]                   bit_cnt_reg;
   logic [15:0]                  rx_shift_reg;
   logic [15:0]                  rb_reg;
   logic [15:0]                  cmd_reg;
   logic                         sdo_reg;
   logic                         cmd_valid_reg, frame_error_reg, wdog_timeout_reg;
   logic [WDOG_WIDTH-1:0]        wdog_cnt_reg;
   logic                         commit_ok;

   assign async_in = {sdi, cs_n, sclk};

   // cs_n chain resets to 0 so a select held low across reset is never seen as a fresh fall
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_reg      <= '0;
         sclk_prev_reg <= 1'b0;
         cs_prev_reg   <= 1'b0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            sync_reg[i] <= {sync_reg[i][SYNC_STAGES-2:0], async_in[i]};
         end
         sclk_prev_reg <= sclk_s;
         cs_prev_reg   <= cs_s;
      end
   end

   assign sclk_s    = sync_reg[0][SYNC_STAGES-1];
   assign cs_s      = sync_reg[1][SYNC_STAGES-1];
   assign sdi_s     = sync_reg[2][SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_prev_reg;
   assign sclk_fall = ~sclk_s & sclk_prev_reg;
   assign cs_rise   = cs_s & ~cs_prev_reg;
   assign cs_fall   = ~cs_s & cs_prev_reg;

   assign commit_ok = (state_reg == COMMIT) && (bit_cnt_reg == 5'd16);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg        <= WAIT_IDLE;
         bit_cnt_reg      <= '0;
         rx_shift_reg     <= '0;
         rb_reg           <= '0;
         cmd_reg          <= '0;
         sdo_reg          <= 1'b0;
         cmd_valid_reg    <= 1'b0;
         frame_error_reg  <= 1'b0;
         wdog_timeout_reg <= 1'b0;
         wdog_cnt_reg     <= '0;
      end else begin
         cmd_valid_reg   <= 1'b0;
         frame_error_reg <= 1'b0;
         sdo_reg         <= (state_reg == SHIFT) && rb_reg[15];

         case (state_reg)
            WAIT_IDLE: begin
               if (cs_s) state_reg <= IDLE;
            end
            IDLE: begin
               if (cs_fall) begin
                  bit_cnt_reg <= '0;
                  rb_reg      <= cmd_reg;
                  state_reg   <= SHIFT;
               end
            end
            SHIFT: begin
               if (sclk_rise) begin
                  rx_shift_reg <= {rx_shift_reg[14:0], sdi_s};
                  if (bit_cnt_reg != 5'd17) bit_cnt_reg <= bit_cnt_reg + 5'd1;
               end
               // zero fill leaves sdo low once all 16 readback bits have gone out
               if (sclk_fall) rb_reg <= {rb_reg[14:0], 1'b0};
               if (cs_rise) state_reg <= COMMIT;
            end
            COMMIT: begin
               state_reg <= IDLE;
               if (bit_cnt_reg != 5'd16 && bit_cnt_reg != 5'd0) frame_error_reg <= 1'b1;
            end
            default: state_reg <= WAIT_IDLE;
         endcase

         // a valid commit takes priority over a coincident watchdog expiry
         if (commit_ok) begin
            cmd_reg          <= rx_shift_reg;
            cmd_valid_reg    <= 1'b1;
            wdog_cnt_reg     <= '0;
            wdog_timeout_reg <= 1'b0;
         end else if (!wdog_timeout_reg) begin
            if (wdog_cnt_reg == WDOG_LAST) begin
               wdog_timeout_reg <= 1'b1;
               cmd_reg          <= '0;
            end else begin
               wdog_cnt_reg <= wdog_cnt_reg + 1'b1;
            end
         end
      end
   end

   assign sdo           = sdo_reg;
   assign motor1_sign   = cmd_reg[15];
   assign motor1_period = cmd_reg[14:8];
   assign motor2_sign   = cmd_reg[7];
   assign motor2_period = cmd_reg[6:0];
   assign cmd_valid     = cmd_valid_reg;
   assign frame_error   = frame_error_reg;
   assign wdog_timeout  = wdog_timeout_reg;

endmodule

// File: tb/tb_motor_cmd_spi_rx.sv
// Bench for motor_cmd_spi_rx: directed frame table, hand sequences for watchdog and
// mid-frame reset, then random frames checked against a frame-level model.
module tb_motor_cmd_spi_rx;

   localparam int LIMIT = 1000;

   logic       clk = 1'b0;
   logic       reset, sclk, cs_n, sdi;
   logic       sdo, motor1_sign, motor2_sign, cmd_valid, frame_error, wdog_timeout;
   logic [6:0] motor1_period, motor2_period;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int cv_cnt = 0;
   int fe_cnt = 0;
   int last_cv_cyc = 0;

   // frame-level model: last command accepted and the cycle its cs_n was raised
   logic [15:0] mdl_cmd;
   int          mdl_ref;

   typedef struct {
      logic [17:0] data;
      int          nbits;
      int          gap;
      int          exp_cv;
      int          exp_fe;
      logic [15:0] exp_cmd;
      logic        chk_rb;
      logic [15:0] exp_rb;
   } vec_t;

   vec_t tbl[6];

   motor_cmd_spi_rx #(
      .SYNC_STAGES(2),
      .WDOG_WIDTH (24),
      .WDOG_LIMIT (LIMIT)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .sclk         (sclk),
      .cs_n         (cs_n),
      .sdi          (sdi),
      .sdo          (sdo),
      .motor1_sign  (motor1_sign),
      .motor1_period(motor1_period),
      .motor2_sign  (motor2_sign),
      .motor2_period(motor2_period),
      .cmd_valid    (cmd_valid),
      .frame_error  (frame_error),
      .wdog_timeout (wdog_timeout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (cmd_valid) begin
         cv_cnt      <= cv_cnt + 1;
         last_cv_cyc <= cyc;
      end
      if (frame_error) fe_cnt <= fe_cnt + 1;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] outs();
      return {motor1_sign, motor1_period, motor2_sign, motor2_period};
   endfunction

   function automatic logic [17:0] rb_stream(input logic [15:0] v, input int n);
      logic [17:0] e = '0;
      for (int i = 0; i < n; i++) e = {e[16:0], (i < 16) ? v[15-i] : 1'b0};
      return e;
   endfunction

   // one mode-0 bit: data set mid-low phase, sdo sampled just before the rising edge
   task automatic clock_bit(input logic b, output logic s);
      sdi = b;
      tick(3);
      s = sdo;
      sclk = 1'b1;
      tick(6);
      sclk = 1'b0;
      tick(3);
   endtask

   task automatic send_frame(input logic [17:0] data, input int n, output logic [17:0] sb,
                             output int cv, output int fe, output int f_cyc, output int r_cyc);
      int   cv0 = cv_cnt;
      int   fe0 = fe_cnt;
      logic s;
      sb = '0;
      cs_n = 1'b0;
      f_cyc = cyc;
      tick(8);
      for (int i = 0; i < n; i++) begin
         clock_bit(data[n-1-i], s);
         sb = {sb[16:0], s};
      end
      tick(3);
      cs_n = 1'b1;
      r_cyc = cyc;
      tick(12);
      cv = cv_cnt - cv0;
      fe = fe_cnt - fe0;
      if (n == 16) begin
         mdl_cmd = data[15:0];
         mdl_ref = r_cyc;
      end
   endtask

   initial begin
      logic [17:0] sb;
      logic        s, sdo_seen;
      int          cv, fe, f_cyc, r_cyc, el, cv0, fe0, rel;
      logic [15:0] pcmd;
      int          pref, n, g;
      logic [17:0] data;

      tbl[0] = '{18'h0A53C, 16, 4, 1, 0, 16'hA53C, 1'b1, 16'h0000};
      tbl[1] = '{18'h00000, 16, 4, 1, 0, 16'h0000, 1'b1, 16'hA53C};
      tbl[2] = '{18'h01234, 16, 4, 1, 0, 16'h1234, 1'b1, 16'h0000};
      tbl[3] = '{18'h05555, 15, 4, 0, 1, 16'h1234, 1'b1, 16'h1234};
      tbl[4] = '{18'h2AAAA, 18, 4, 0, 1, 16'h1234, 1'b1, 16'h1234};
      tbl[5] = '{18'h00000,  0, 4, 0, 0, 16'h1234, 1'b0, 16'h0000};

      reset = 1'b0; sclk = 1'b0; cs_n = 1'b1; sdi = 1'b0;
      tick(4);
      chk("reset_outs", outs(), 16'h0000);
      chk("reset_cmd_valid", cmd_valid, 0);
      chk("reset_frame_error", frame_error, 0);
      chk("reset_wdog", wdog_timeout, 0);
      chk("reset_sdo", sdo, 0);
      reset = 1'b1;
      mdl_cmd = '0;
      mdl_ref = cyc - 3;
      tick(10);

      for (int i = 0; i < 6; i++) begin
         tick(tbl[i].gap);
         send_frame(tbl[i].data, tbl[i].nbits, sb, cv, fe, f_cyc, r_cyc);
         $display("vec %0d: data=%h bits=%0d cv=%0d fe=%0d outs=%h sdo=%h", i, tbl[i].data,
                  tbl[i].nbits, cv, fe, outs(), sb);
         chk($sformatf("vec%0d_cmd_valid", i), cv, tbl[i].exp_cv);
         chk($sformatf("vec%0d_frame_error", i), fe, tbl[i].exp_fe);
         chk($sformatf("vec%0d_outs", i), outs(), tbl[i].exp_cmd);
         chk($sformatf("vec%0d_wdog", i), wdog_timeout, 0);
         if (tbl[i].chk_rb)
            chk($sformatf("vec%0d_readback", i), sb, rb_stream(tbl[i].exp_rb, tbl[i].nbits));
         if (tbl[i].exp_cv == 1)
            chk($sformatf("vec%0d_latency_ok", i),
                (last_cv_cyc - r_cyc >= 3 && last_cv_cyc - r_cyc <= 5), 1);
      end

      // sclk activity while deselected must be ignored
      cv0 = cv_cnt; fe0 = fe_cnt; sdo_seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         clock_bit(1'($urandom_range(0, 1)), s);
         sdo_seen = sdo_seen | s;
      end
      tick(8);
      $display("idle sclk: cv=%0d fe=%0d outs=%h sdo=%b", cv_cnt - cv0, fe_cnt - fe0, outs(), sdo_seen);
      chk("idle_sclk_cv", cv_cnt - cv0, 0);
      chk("idle_sclk_fe", fe_cnt - fe0, 0);
      chk("idle_sclk_outs", outs(), mdl_cmd);
      chk("idle_sclk_sdo", sdo_seen, 0);

      // cs_n pulse with no sclk
      send_frame(18'h0, 0, sb, cv, fe, f_cyc, r_cyc);
      $display("empty frame: cv=%0d fe=%0d", cv, fe);
      chk("empty_cv", cv, 0);
      chk("empty_fe", fe, 0);

      // watchdog expiry exactly LIMIT cycles after cmd_valid
      send_frame(18'h07F7F, 16, sb, cv, fe, f_cyc, r_cyc);
      chk("wd_apply_cv", cv, 1);
      while (cyc < last_cv_cyc + LIMIT - 1) tick(1);
      $display("wdog pre-expiry: wdog=%b outs=%h", wdog_timeout, outs());
      chk("wd_pre_timeout", wdog_timeout, 0);
      chk("wd_pre_outs", outs(), 16'h7F7F);
      tick(1);
      $display("wdog expiry: wdog=%b outs=%h", wdog_timeout, outs());
      chk("wd_timeout", wdog_timeout, 1);
      chk("wd_forced_outs", outs(), 16'h0000);
      tick(5);
      send_frame(18'h00101, 16, sb, cv, fe, f_cyc, r_cyc);
      $display("wdog recovery: cv=%0d wdog=%b outs=%h sdo=%h", cv, wdog_timeout, outs(), sb);
      chk("wd_recover_cv", cv, 1);
      chk("wd_recover_timeout", wdog_timeout, 0);
      chk("wd_recover_outs", outs(), 16'h0101);
      chk("wd_recover_readback", sb, 18'h0);

      // reset asserted after bit 8 and released with cs_n still low
      cv0 = cv_cnt; fe0 = fe_cnt;
      cs_n = 1'b0;
      tick(8);
      for (int i = 0; i < 8; i++) clock_bit(1'b1, s);
      reset = 1'b0;
      tick(3);
      reset = 1'b1;
      rel = cyc;
      for (int i = 0; i < 8; i++) clock_bit(1'b1, s);
      tick(3);
      cs_n = 1'b1;
      tick(12);
      mdl_cmd = '0;
      mdl_ref = rel - 3;
      $display("mid-frame reset: cv=%0d fe=%0d outs=%h", cv_cnt - cv0, fe_cnt - fe0, outs());
      chk("midrst_cv", cv_cnt - cv0, 0);
      chk("midrst_fe", fe_cnt - fe0, 0);
      chk("midrst_outs", outs(), 16'h0000);
      send_frame(18'h05AC3, 16, sb, cv, fe, f_cyc, r_cyc);
      $display("post-reset frame: cv=%0d outs=%h", cv, outs());
      chk("midrst_next_cv", cv, 1);
      chk("midrst_next_outs", outs(), 16'h5AC3);

      // random frames against the model; watchdog-dependent checks skip the edge window
      for (int k = 0; k < 40; k++) begin
         g    = ($urandom_range(0, 4) == 0) ? 1100 : int'($urandom_range(2, 30));
         n    = ($urandom_range(0, 9) < 6) ? 16 : int'($urandom_range(0, 18));
         data = 18'($urandom);
         tick(g);
         pcmd = mdl_cmd;
         pref = mdl_ref;
         send_frame(data, n, sb, cv, fe, f_cyc, r_cyc);
         $display("rnd %0d: data=%h bits=%0d gap=%0d cv=%0d fe=%0d outs=%h wdog=%b sdo=%h",
                  k, data, n, g, cv, fe, outs(), wdog_timeout, sb);
         chk("rnd_cv", cv, (n == 16) ? 1 : 0);
         chk("rnd_fe", fe, (n != 16 && n != 0) ? 1 : 0);
         el = f_cyc - pref;
         if (el <= LIMIT - 2)      chk("rnd_readback", sb, rb_stream(pcmd, n));
         else if (el >= LIMIT + 4) chk("rnd_readback_zero", sb, rb_stream(16'h0, n));
         if (n == 16) begin
            chk("rnd_outs", outs(), data[15:0]);
            chk("rnd_wdog", wdog_timeout, 0);
         end else begin
            el = cyc - pref;
            if (el <= LIMIT + 2) begin
               chk("rnd_hold_outs", outs(), pcmd);
               chk("rnd_hold_wdog", wdog_timeout, 0);
            end else if (el >= LIMIT + 6) begin
               chk("rnd_expired_outs", outs(), 16'h0000);
               chk("rnd_expired_wdog", wdog_timeout, 1);
            end
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
